nts_api_arbiter: RTL and testbench

Two-master arbiter in front of the NTS engine API decode pipeline. Shares the single external API port (cs/we/12-bit address/32-bit data, read data returned with a valid strobe four cycles after cs) between the host bus bridge (port A) and the on-chip debug/command bridge (port B). Keeps exactly one transaction in flight, alternates fairly between masters, and recovers from a lost read-data-valid with a timeout.

---
 rtl/nts_api_pkg.sv | 18 +
 rtl/nts_api_rr_arbiter.sv | 33 +++
 rtl/nts_api_arbiter.sv | 158 +++++++++++++++
 tb/tb_nts_api_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nts_api_pkg.sv
// rtl/nts_api_pkg.sv - shared widths, grant and FSM encodings for the NTS API arbiter
package nts_api_pkg;

  localparam int API_ADDR_W = 12;
  localparam int API_DATA_W = 32;
  localparam int CNT_W      = 8;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

endpackage

// File: rtl/nts_api_rr_arbiter.sv
// rtl/nts_api_rr_arbiter.sv - two-input round-robin grant with last-grant memory
module nts_api_rr_arbiter
  import nts_api_pkg::*;
(
  input  logic i_clk,
  input  logic i_areset_n,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_grant
);

  logic r_last_grant;

  // On a tie the master not served last wins; a lone requester always wins.
  always_comb begin
    o_grant = GRANT_A;
    if (i_req_a && i_req_b) begin
      o_grant = (r_last_grant == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (i_req_b) begin
      o_grant = GRANT_B;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_last_grant <= GRANT_B;
    end else if (i_update) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/nts_api_arbiter.sv
// rtl/nts_api_arbiter.sv - shares the NTS engine API port between host (A) and debug (B) masters
module nts_api_arbiter
  import nts_api_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic [API_ADDR_W-1:0] i_a_address,
  input  logic [API_DATA_W-1:0] i_a_write_data,
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [API_ADDR_W-1:0] i_b_address,
  input  logic [API_DATA_W-1:0] i_b_write_data,
  output logic                  o_a_ack,
  output logic                  o_a_error,
  output logic                  o_b_ack,
  output logic                  o_b_error,
  output logic [API_DATA_W-1:0] o_read_data,
  output logic                  o_api_cs,
  output logic                  o_api_we,
  output logic [API_ADDR_W-1:0] o_api_address,
  output logic [API_DATA_W-1:0] o_api_write_data,
  input  logic [API_DATA_W-1:0] i_api_read_data,
  input  logic                  i_api_read_data_valid,
  input  logic                  i_api_busy
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nx;
  logic                  w_grant_en;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_resp_ok;
  logic                  w_resp_to;
  logic                  w_resp_done;
  logic                  w_rr_grant;

  logic                  r_grant;
  logic                  r_we;
  logic [API_ADDR_W-1:0] r_addr;
  logic [API_DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_api_cs;
  logic [API_DATA_W-1:0] r_read_data;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic                  r_a_error;
  logic                  r_b_error;

  nts_api_rr_arbiter u_rr (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_req_a    (i_a_req),
    .i_req_b    (i_b_req),
    .i_update   (w_grant_en),
    .o_grant    (w_rr_grant)
  );

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_grant_en = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_resp_ok  = 1'b0;
    w_resp_to  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_api_busy && (i_a_req || i_b_req)) begin
          w_grant_en = 1'b1;
          w_state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_clr  = 1'b1;
        w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving on the last counted cycle still counts as success.
        if (i_api_read_data_valid) begin
          w_resp_ok  = 1'b1;
          w_state_nx = ST_RESPOND;
        end else if (r_cnt == TO_LAST) begin
          w_resp_to  = 1'b1;
          w_state_nx = ST_RESPOND;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RESPOND: w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  assign w_resp_done = w_resp_ok | w_resp_to;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_grant     <= GRANT_A;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_api_cs    <= 1'b0;
      r_read_data <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_error   <= 1'b0;
      r_b_error   <= 1'b0;
    end else begin
      r_api_cs  <= w_grant_en;
      r_a_ack   <= w_resp_done && (r_grant == GRANT_A);
      r_b_ack   <= w_resp_done && (r_grant == GRANT_B);
      r_a_error <= w_resp_to && (r_grant == GRANT_A);
      r_b_error <= w_resp_to && (r_grant == GRANT_B);
      // Fields are frozen at grant so later requester activity cannot disturb the cycle.
      if (w_grant_en) begin
        r_grant <= w_rr_grant;
        r_we    <= (w_rr_grant == GRANT_B) ? i_b_we         : i_a_we;
        r_addr  <= (w_rr_grant == GRANT_B) ? i_b_address    : i_a_address;
        r_wdata <= (w_rr_grant == GRANT_B) ? i_b_write_data : i_a_write_data;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_resp_ok) begin
        r_read_data <= i_api_read_data;
      end else if (w_resp_to) begin
        r_read_data <= '0;
      end
    end
  end

  assign o_a_ack          = r_a_ack;
  assign o_b_ack          = r_b_ack;
  assign o_a_error        = r_a_error;
  assign o_b_error        = r_b_error;
  assign o_read_data      = r_read_data;
  assign o_api_cs         = r_api_cs;
  assign o_api_we         = r_we;
  assign o_api_address    = r_addr;
  assign o_api_write_data = r_wdata;

endmodule

// File: tb/tb_nts_api_arbiter.sv
// tb/tb_nts_api_arbiter.sv - scoreboard bench for nts_api_arbiter
module tb_nts_api_arbiter;

  localparam int TO = 16;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        drop;
  } txn_t;

  typedef struct {
    logic        m;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [11:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] rdata;
  logic        api_cs, api_we;
  logic [11:0] api_addr;
  logic [31:0] api_wdata;
  logic [31:0] api_rdata = '0;
  logic        api_valid = 1'b0;
  logic        api_busy = 1'b0;

  nts_api_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_areset_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_address(a_addr), .i_a_write_data(a_wdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_address(b_addr), .i_b_write_data(b_wdata),
    .o_a_ack(a_ack), .o_a_error(a_err), .o_b_ack(b_ack), .o_b_error(b_err),
    .o_read_data(rdata), .o_api_cs(api_cs), .o_api_we(api_we),
    .o_api_address(api_addr), .o_api_write_data(api_wdata),
    .i_api_read_data(api_rdata), .i_api_read_data_valid(api_valid), .i_api_busy(api_busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  txn_t qa[$];
  txn_t qb[$];
  exp_t exp_q[$];
  logic grant_log[$];
  txn_t cur;
  logic inflight = 1'b0;
  logic pend = 1'b0;
  logic m_last = 1'b1;
  int   last_cs = -100;
  int   resp_due = -1;
  logic spur_en = 1'b0;
  logic rnd_busy = 1'b0;
  logic late_valid = 1'b0;
  logic a_ovr_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    a_req = (qa.size() > 0);
    b_req = (qb.size() > 0);
    if (qa.size() > 0) begin
      a_we    = qa[0].we;
      a_addr  = a_ovr_en ? 12'h080 : qa[0].addr;
      a_wdata = qa[0].wdata;
    end
    if (qb.size() > 0) begin
      b_we    = qb[0].we;
      b_addr  = qb[0].addr;
      b_wdata = qb[0].wdata;
    end
    if (rnd_busy) api_busy = ($urandom_range(0, 4) == 0);
    if (resp_due == cyc) begin
      api_valid = 1'b1;
      api_rdata = cur.rdata;
    end else if (!inflight && (late_valid || (spur_en && $urandom_range(0, 9) == 0))) begin
      api_valid  = 1'b1;
      api_rdata  = $urandom;
      late_valid = 1'b0;
    end else begin
      api_valid = 1'b0;
      api_rdata = $urandom;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      apply();
    end
  endtask

  task automatic enq(input logic m, input logic we, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rd, input logic drop);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rd; t.drop = drop;
    if (m) qb.push_back(t);
    else   qa.push_back(t);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_a_ack"}, {31'd0, a_ack}, 0);
    chk({tag, "_b_ack"}, {31'd0, b_ack}, 0);
    chk({tag, "_a_err"}, {31'd0, a_err}, 0);
    chk({tag, "_b_err"}, {31'd0, b_err}, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_cs"}, {31'd0, api_cs}, 0);
    chk({tag, "_we"}, {31'd0, api_we}, 0);
    chk({tag, "_addr"}, {20'd0, api_addr}, 0);
    chk({tag, "_wdata"}, api_wdata, 0);
  endtask

  // Monitor: predicts grants from the request levels it sees, checks the strobe,
  // and pops the scoreboard whenever the DUT presents an ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      inflight = 1'b0;
      pend     = 1'b0;
      m_last   = 1'b1;
      resp_due = -1;
      exp_q.delete();
    end else begin
      chk("cs_strobe", {31'd0, api_cs}, {31'd0, pend});
      if (pend && api_cs) begin
        chk("cs_we", {31'd0, api_we}, {31'd0, cur.we});
        chk("cs_addr", {20'd0, api_addr}, {20'd0, cur.addr});
        chk("cs_wdata", api_wdata, cur.wdata);
        chk("cs_spacing_ok", {31'd0, (cyc - last_cs) >= 6}, 1);
        last_cs = cyc;
        if (!cur.drop) resp_due = cyc + 4;
      end
      pend = 1'b0;
      if (!inflight && !api_busy && (a_req || b_req)) begin
        logic ch;
        exp_t e;
        ch = (a_req && b_req) ? ~m_last : b_req;
        if ((ch && qb.size() == 0) || (!ch && qa.size() == 0)) begin
          chk("req_without_txn", 0, 1);
        end else begin
          cur    = ch ? qb[0] : qa[0];
          e.m    = ch;
          e.err  = cur.drop;
          e.data = cur.drop ? 32'h0 : cur.rdata;
          exp_q.push_back(e);
          m_last   = ch;
          inflight = 1'b1;
          pend     = 1'b1;
        end
      end
      if (a_ack || b_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, b_ack, a_ack}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_a", {31'd0, a_ack}, {31'd0, ~e.m});
          chk("ack_b", {31'd0, b_ack}, {31'd0, e.m});
          chk("ack_error", {31'd0, e.m ? b_err : a_err}, {31'd0, e.err});
          chk("ack_other_error", {31'd0, e.m ? a_err : b_err}, 0);
          chk("ack_data", rdata, e.data);
          chk("ack_latency", cyc - last_cs, e.err ? TO + 1 : 5);
          grant_log.push_back(b_ack);
          if (e.m) void'(qb.pop_front());
          else     void'(qa.pop_front());
          inflight = 1'b0;
          resp_due = -1;
        end
      end else if (a_err || b_err) begin
        chk("error_without_ack", {30'd0, b_err, a_err}, 0);
      end
    end
  end

  initial begin
    int issued;
    int guard;
    logic done;
    step(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Contention straight after reset: A wins the first tie, then strict alternation.
    grant_log.delete();
    enq(0, 0, 12'h101, 32'h0, 32'h1111_0001, 0);
    enq(0, 1, 12'h102, 32'hA5A5_0002, 32'h1111_0002, 0);
    enq(1, 0, 12'h201, 32'h0, 32'h2222_0001, 0);
    enq(1, 1, 12'h202, 32'h5A5A_0002, 32'h2222_0002, 0);
    step(40);
    chk("contention_count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("contention_order", {28'd0, grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 32'b0101);
    end

    enq(0, 0, 12'h010, 32'h0, 32'hCAFE_F00D, 0);
    step(12);

    // Timeout on a B write, then a late valid that must be ignored.
    enq(1, 1, 12'h300, 32'h1234_5678, 32'hDEAD_BEEF, 1);
    step(TO + 6);
    late_valid = 1'b1;
    step(6);

    api_busy = 1'b1;
    enq(0, 0, 12'h044, 32'h0, 32'h0BAD_CAFE, 0);
    step(10);
    api_busy = 1'b0;
    step(10);

    // Address changes the cycle after grant; downstream must still see the original.
    enq(0, 0, 12'h020, 32'h0, 32'h2020_2020, 0);
    step(1);
    a_ovr_en = 1'b1;
    step(10);
    a_ovr_en = 1'b0;

    // Reset while in WAIT: everything clears, no ack, and the next tie goes to A.
    enq(0, 1, 12'h5A5, 32'hFEED_0001, 32'h7777_7777, 0);
    step(3);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    qa.delete();
    qb.delete();
    step(2);
    rst_n = 1'b1;
    grant_log.delete();
    step(8);
    chk("post_reset_no_ack", grant_log.size(), 0);
    enq(1, 0, 12'h0B0, 32'h0, 32'h0000_00B0, 0);
    enq(0, 0, 12'h0A0, 32'h0, 32'h0000_00A0, 0);
    step(20);
    chk("post_reset_count", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("post_reset_tie_a", {31'd0, grant_log[0]}, 0);

    spur_en  = 1'b1;
    rnd_busy = 1'b1;
    issued   = 0;
    guard    = 0;
    while (issued < 60 && guard < 20000) begin
      if (qa.size() < 2 && $urandom_range(0, 3) == 0) begin
        enq(0, 1'($urandom_range(0, 1)), 12'($urandom), $urandom, $urandom, $urandom_range(0, 9) == 0);
        issued++;
      end
      if (qb.size() < 2 && $urandom_range(0, 3) == 0) begin
        enq(1, 1'($urandom_range(0, 1)), 12'($urandom), $urandom, $urandom, $urandom_range(0, 9) == 0);
        issued++;
      end
      step(1);
      guard++;
    end
    rnd_busy = 1'b0;
    api_busy = 1'b0;

    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      step(1);
      done = (qa.size() == 0) && (qb.size() == 0) && !inflight;
    end
    chk("drain", {31'd0, done}, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
